// File: rtl/fp_align_shift_pipe.sv
// ---------------------------------------------------------------------------
// fp_align_shift_pipe
//
// Pipelined mantissa shifter for the floating-point datapath. One operation
// per cycle, fixed latency of PIPE_STAGES cycles, global stall under
// backpressure.
//
//   mode 0/3 : exponent-alignment right shift with guard/round/sticky
//   mode 1   : left shift with overflow detect
//   mode 2   : leading-zero normalisation (Y = X << lzc)
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid, in_ready   upstream handshake (in_ready = advance)
//   mode, X, shamt       operation select, operand, shift amount
//   out_valid, out_ready downstream handshake
//   Y                    shifted result
//   guard, round, sticky bits lost below Y[0] (align only)
//   ovf                  a 1 bit left the MSB (left shift only)
//   lzc                  leading-zero count of X (normalise only)
//   zero                 X == 0 (all modes)
// ---------------------------------------------------------------------------
module fp_align_shift_pipe #(
   parameter int WIDTH       = 24,
   parameter int SHW         = 8,
   parameter int PIPE_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] X,
   input  logic [SHW-1:0]   shamt,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Y,
   output logic             guard,
   output logic             round,
   output logic             sticky,
   output logic             ovf,
   output logic [SHW-1:0]   lzc,
   output logic             zero
);

   // Packed result word carried down the pipe: {Y, G, R, S, ovf, lzc, zero}
   localparam int RW = WIDTH + SHW + 5;

   logic                   advance;
   logic [RW-1:0]          comp;
   logic [RW-1:0]          stage_data [PIPE_STAGES];
   logic [PIPE_STAGES-1:0] stage_valid;

   // X placed above 2*WIDTH zero bits: for any shift up to WIDTH+1 no set
   // bit of X can fall off the bottom, so the OR of everything below the
   // round position is the complete sticky.
   logic [3*WIDTH-1:0]     align_ext;
   logic [2*WIDTH-1:0]     left_ext;
   logic [SHW-1:0]         lz;

   logic [WIDTH-1:0]       y_c;
   logic                   g_c, r_c, s_c, ovf_c, zero_c;
   logic [SHW-1:0]         lzc_c;

   assign align_ext = {X, {(2*WIDTH){1'b0}}} >> shamt;
   assign left_ext  = {{WIDTH{1'b0}}, X} << shamt;

   // Leading-zero count: ascending scan, so the highest set bit wins.
   always_comb begin
      lz = SHW'(WIDTH);
      for (int i = 0; i < WIDTH; i++) begin
         if (X[i]) lz = SHW'(WIDTH - 1 - i);
      end
   end

   // Shift datapath; all work is done before the first register and the
   // remaining stages only carry the result.
   always_comb begin
      y_c    = '0;
      g_c    = 1'b0;
      r_c    = 1'b0;
      s_c    = 1'b0;
      ovf_c  = 1'b0;
      lzc_c  = '0;
      zero_c = (X == '0);
      case (mode)
         2'd1: begin
            if (32'(shamt) >= WIDTH) begin
               ovf_c = |X;
            end else begin
               y_c   = left_ext[WIDTH-1:0];
               ovf_c = |left_ext[2*WIDTH-1:WIDTH];
            end
         end
         2'd2: begin
            lzc_c = lz;
            y_c   = X << lz;
         end
         default: begin
            // Beyond WIDTH+1 every bit of X lies below the round position.
            if (32'(shamt) >= WIDTH + 2) begin
               s_c = |X;
            end else begin
               y_c = align_ext[3*WIDTH-1:2*WIDTH];
               g_c = align_ext[2*WIDTH-1];
               r_c = align_ext[2*WIDTH-2];
               s_c = |align_ext[2*WIDTH-3:0];
            end
         end
      endcase
   end

   assign comp = {y_c, g_c, r_c, s_c, ovf_c, lzc_c, zero_c};

   // Global stall: the whole pipe moves only when the output slot is free
   // or being consumed.
   assign out_valid = stage_valid[PIPE_STAGES-1];
   assign advance   = out_ready || !out_valid;
   assign in_ready  = advance;

   // Stage registers. Bubbles clear their valid but leave data untouched.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stage_valid <= '0;
         for (int s = 0; s < PIPE_STAGES; s++) stage_data[s] <= '0;
      end else if (advance) begin
         stage_valid[0] <= in_valid;
         if (in_valid) stage_data[0] <= comp;
         for (int s = 1; s < PIPE_STAGES; s++) begin
            stage_valid[s] <= stage_valid[s-1];
            if (stage_valid[s-1]) stage_data[s] <= stage_data[s-1];
         end
      end
   end

   assign {Y, guard, round, sticky, ovf, lzc, zero} = stage_data[PIPE_STAGES-1];

endmodule

// File: tb/tb_fp_align_shift_pipe.sv
// ---------------------------------------------------------------------------
// tb_fp_align_shift_pipe
//
// Directed testbench for fp_align_shift_pipe (WIDTH=24, SHW=8, PIPE_STAGES=2).
// Hand-computed vectors are streamed through the pipe; a negedge monitor
// pairs each accepted operation with its result in order and checks latency.
// ---------------------------------------------------------------------------
module tb_fp_align_shift_pipe;

   localparam int WIDTH = 24;
   localparam int SHW   = 8;
   localparam int P     = 2;
   localparam int NV    = 20;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       mode;
   logic [WIDTH-1:0] X;
   logic [SHW-1:0]   shamt;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] Y;
   logic             guard, round, sticky, ovf, zero;
   logic [SHW-1:0]   lzc;

   typedef struct {
      logic [1:0]       m;
      logic [WIDTH-1:0] x;
      logic [SHW-1:0]   sh;
      logic [WIDTH-1:0] y;
      logic             g, r, s, o;
      logic [SHW-1:0]   l;
      logic             z;
   } vec_t;

   vec_t vecs [NV];

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int readyDrops = 0;
   bit latChk   = 0;
   bit streamMon = 0;

   logic [36:0] curExp;
   int          curIdx;
   logic [36:0] expQ [$];
   int          accQ [$];
   int          tagQ [$];

   wire [36:0] res = {Y, guard, round, sticky, ovf, lzc, zero};

   fp_align_shift_pipe #(.WIDTH(WIDTH), .SHW(SHW), .PIPE_STAGES(P)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .mode(mode), .X(X), .shamt(shamt),
      .out_valid(out_valid), .out_ready(out_ready),
      .Y(Y), .guard(guard), .round(round), .sticky(sticky),
      .ovf(ovf), .lzc(lzc), .zero(zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [63:0] act,
                              input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s got=%h want=%h", tag, act, exp);
      end
   endtask

   // Present vector idx and hold it until the DUT accepts it.
   task automatic applyStimulus(input int idx);
      bit ok;
      ok       = 1'b0;
      mode     = vecs[idx].m;
      X        = vecs[idx].x;
      shamt    = vecs[idx].sh;
      curExp   = {vecs[idx].y, vecs[idx].g, vecs[idx].r, vecs[idx].s,
                  vecs[idx].o, vecs[idx].l, vecs[idx].z};
      curIdx   = idx;
      in_valid = 1'b1;
      for (int k = 0; k < 200 && !ok; k++) begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         #1;
      end
      if (!ok) checkOutput("accept_timeout", 64'(ok), 64'd1);
   endtask

   // Wait (bounded) for all outstanding results, then watch a few extra
   // cycles so a duplicated result would hit the empty queue.
   task automatic waitDrain(input string tag);
      for (int k = 0; k < 100 && expQ.size() != 0; k++) @(posedge clk);
      checkOutput(tag, 64'(expQ.size()), 64'd0);
      repeat (P + 2) @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor: retire results first, then record new accepts.
   always @(negedge clk) begin
      if (rst_n) begin
         if (out_valid && out_ready) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpected_result", 64'd1, 64'd0);
            end else begin
               logic [36:0] e;
               int a, t;
               e = expQ.pop_front();
               a = accQ.pop_front();
               t = tagQ.pop_front();
               checkOutput($sformatf("result_vec%0d", t), 64'(res), 64'(e));
               if (latChk) checkOutput($sformatf("latency_vec%0d", t),
                                       64'(cyc - a), 64'(P));
            end
         end
         if (in_valid && in_ready) begin
            expQ.push_back(curExp);
            accQ.push_back(cyc);
            tagQ.push_back(curIdx);
         end
         if (streamMon && !in_ready) readyDrops++;
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      //            mode  X           shamt    Y           G     R     S     ovf   lzc     zero
      vecs[0]  = '{2'd0, 24'hC00001, 8'd1,   24'h600000, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0,  1'b0};
      vecs[1]  = '{2'd0, 24'hC00001, 8'd3,   24'h180000, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0,  1'b0};
      vecs[2]  = '{2'd0, 24'hC00001, 8'd24,  24'h000000, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0,  1'b0};
      vecs[3]  = '{2'd0, 24'hC00001, 8'd200, 24'h000000, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0,  1'b0};
      vecs[4]  = '{2'd0, 24'hC00001, 8'd25,  24'h000000, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0,  1'b0};
      vecs[5]  = '{2'd0, 24'hC00001, 8'd26,  24'h000000, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0,  1'b0};
      vecs[6]  = '{2'd0, 24'hC00001, 8'd0,   24'hC00001, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0,  1'b0};
      vecs[7]  = '{2'd1, 24'h800001, 8'd1,   24'h000002, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0,  1'b0};
      vecs[8]  = '{2'd1, 24'h800001, 8'd0,   24'h800001, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0,  1'b0};
      vecs[9]  = '{2'd1, 24'h000001, 8'd23,  24'h800000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0,  1'b0};
      vecs[10] = '{2'd1, 24'h000001, 8'd24,  24'h000000, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0,  1'b0};
      vecs[11] = '{2'd3, 24'hC00001, 8'd1,   24'h600000, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0,  1'b0};
      vecs[12] = '{2'd2, 24'h000F00, 8'd5,   24'hF00000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd12, 1'b0};
      vecs[13] = '{2'd2, 24'h000000, 8'd7,   24'h000000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd24, 1'b1};
      vecs[14] = '{2'd2, 24'h800000, 8'd0,   24'h800000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0,  1'b0};
      vecs[15] = '{2'd2, 24'h000001, 8'd0,   24'h800000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd23, 1'b0};
      vecs[16] = '{2'd0, 24'h000000, 8'd5,   24'h000000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0,  1'b1};
      vecs[17] = '{2'd1, 24'h00F000, 8'd4,   24'h0F0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0,  1'b0};
      vecs[18] = '{2'd0, 24'h800000, 8'd23,  24'h000001, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0,  1'b0};
      vecs[19] = '{2'd0, 24'h800000, 8'd47,  24'h000000, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0,  1'b0};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      mode      = 2'd0;
      X         = '0;
      shamt     = '0;
      curExp    = '0;
      curIdx    = 0;

      // Reset state
      #3;
      checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
      checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
      checkOutput("reset_outputs", 64'(res), 64'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Back-to-back stream of all vectors with out_ready held high
      latChk    = 1'b1;
      streamMon = 1'b1;
      for (int i = 0; i < NV; i++) applyStimulus(i);
      in_valid = 1'b0;
      waitDrain("stream_drain");
      streamMon = 1'b0;
      checkOutput("stream_in_ready_drops", 64'(readyDrops), 64'd0);
      latChk = 1'b0;

      // Backpressure: fill the pipe with out_ready low, then hold 5 cycles
      out_ready = 1'b0;
      for (int i = 0; i < P; i++) applyStimulus(2 + i);
      in_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         checkOutput("stall_in_ready", 64'(in_ready), 64'd0);
         checkOutput("stall_hold", 64'({out_valid, res}), 64'({1'b1, expQ[0]}));
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      waitDrain("stall_release_drain");

      // Random out_ready against the scoreboard
      begin
         bit done;
         done = 1'b0;
         fork
            begin
               for (int i = 0; i < 30; i++) applyStimulus((i * 7) % NV);
               in_valid = 1'b0;
               done = 1'b1;
            end
            begin
               while (!done) begin
                  @(posedge clk);
                  #1 out_ready = 1'($urandom_range(0, 1));
               end
               out_ready = 1'b1;
            end
         join
      end
      waitDrain("random_drain");

      // Reset with P operations in flight
      for (int i = 0; i < P; i++) applyStimulus(7 + i);
      in_valid = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      checkOutput("midreset_out_valid", 64'(out_valid), 64'd0);
      checkOutput("midreset_outputs", 64'(res), 64'd0);
      checkOutput("midreset_in_ready", 64'(in_ready), 64'd1);
      expQ.delete();
      accQ.delete();
      tagQ.delete();
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
      latChk = 1'b1;
      applyStimulus(12);
      in_valid = 1'b0;
      waitDrain("post_reset_drain");
      latChk = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
